// File: rtl/dm_lsu.sv
// Data-memory load/store unit: byte/half/word accesses, lane enables, alignment
// exceptions, configurable SRAM read latency and last-store forwarding.
module dm_lsu #(
  parameter int ADDR_W = 9,
  parameter int RD_LAT = 1,
  parameter int FWD_EN = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_adel,
  output logic              resp_ades,
  output logic [ADDR_W-1:0] resp_badvaddr,
  output logic              data_sram_en,
  output logic [3:0]        data_sram_wen,
  output logic [31:0]       data_sram_addr,
  output logic [31:0]       data_sram_wdata,
  input  logic [31:0]       data_sram_rdata
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int PAD_W = 32 - ADDR_W;
  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_FWD   = 3'd3,
    S_EXC   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t state_r, state_s;

  logic [CNT_W-1:0]  wait_cnt_r;
  logic              wr_r;
  logic [1:0]        size_r;
  logic              signed_r;
  logic [ADDR_W-1:0] addr_r;
  logic [3:0]        lane_mask_r;
  logic [31:0]       lane_data_r;

  logic              fwd_valid_r;
  logic [IDX_W-1:0]  fwd_idx_r;
  logic [31:0]       fwd_data_r;
  logic [3:0]        fwd_mask_r;

  logic [IDX_W-1:0]  req_idx_s;
  logic [3:0]        req_mask_s;
  logic              req_mis_s;
  logic              fwd_hit_s;
  logic [31:0]       lane_bits_s;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      2'b00:   m = 4'b0001 << off;
      2'b01:   m = 4'b0011 << off;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      2'b00:   mis = 1'b0;
      2'b01:   mis = off[0];
      default: mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      2'b00:   d = {4{wdata[7:0]}};
      2'b01:   d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] byte_expand(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  // Little-endian lane extraction followed by sign or zero extension.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic sgn, input logic [1:0] off);
    logic [31:0] sh;
    logic [31:0] r;
    sh = word >> {off, 3'b000};
    case (size)
      2'b00:   r = {{24{sgn & sh[7]}}, sh[7:0]};
      2'b01:   r = {{16{sgn & sh[15]}}, sh[15:0]};
      default: r = word;
    endcase
    return r;
  endfunction

  // Request decode: alignment and forward-buffer coverage of the incoming load.
  always_comb begin
    req_idx_s  = req_addr[ADDR_W-1:2];
    req_mask_s = lane_mask(req_size, req_addr[1:0]);
    req_mis_s  = misaligned(req_size, req_addr[1:0]);
    fwd_hit_s  = 1'b0;
    if ((FWD_EN != 0) && !req_wr && fwd_valid_r && (fwd_idx_r == req_idx_s) &&
        ((req_mask_s & ~fwd_mask_r) == 4'b0000)) begin
      fwd_hit_s = 1'b1;
    end else begin
      fwd_hit_s = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (req_valid) begin
          if (req_mis_s) begin
            state_s = S_EXC;
          end else if (fwd_hit_s) begin
            state_s = S_FWD;
          end else begin
            state_s = S_ISSUE;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (wr_r) begin
          state_s = S_DONE;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_cnt_r == CNT_LAST) begin
          state_s = S_DONE;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_FWD:   state_s = S_DONE;
      S_EXC:   state_s = S_DONE;
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  assign lane_bits_s = byte_expand(lane_mask_r);

  // Request capture, SRAM strobes, read-latency counter and response registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      req_ready       <= 1'b1;
      wait_cnt_r      <= {CNT_W{1'b0}};
      wr_r            <= 1'b0;
      size_r          <= 2'b00;
      signed_r        <= 1'b0;
      addr_r          <= {ADDR_W{1'b0}};
      lane_mask_r     <= 4'b0000;
      lane_data_r     <= 32'h0000_0000;
      resp_valid      <= 1'b0;
      resp_rdata      <= 32'h0000_0000;
      resp_adel       <= 1'b0;
      resp_ades       <= 1'b0;
      resp_badvaddr   <= {ADDR_W{1'b0}};
      data_sram_en    <= 1'b0;
      data_sram_wen   <= 4'b0000;
      data_sram_addr  <= 32'h0000_0000;
      data_sram_wdata <= 32'h0000_0000;
    end else begin
      req_ready       <= (state_s == S_IDLE);
      resp_valid      <= 1'b0;
      resp_rdata      <= 32'h0000_0000;
      resp_adel       <= 1'b0;
      resp_ades       <= 1'b0;
      resp_badvaddr   <= {ADDR_W{1'b0}};
      data_sram_en    <= 1'b0;
      data_sram_wen   <= 4'b0000;
      data_sram_addr  <= 32'h0000_0000;
      data_sram_wdata <= 32'h0000_0000;
      case (state_r)
        S_IDLE: begin
          if (req_valid) begin
            wr_r        <= req_wr;
            size_r      <= req_size;
            signed_r    <= req_signed;
            addr_r      <= req_addr;
            lane_mask_r <= req_mask_s;
            lane_data_r <= lane_data(req_size, req_wdata);
            if (state_s == S_ISSUE) begin
              data_sram_en   <= 1'b1;
              data_sram_wen  <= req_wr ? req_mask_s : 4'b0000;
              data_sram_addr <= {{PAD_W{1'b0}}, req_addr[ADDR_W-1:2], 2'b00};
              data_sram_wdata <= req_wr ? lane_data(req_size, req_wdata) : 32'h0000_0000;
            end
          end
        end
        S_ISSUE: begin
          wait_cnt_r <= {CNT_W{1'b0}};
          if (wr_r) begin
            resp_valid <= 1'b1;
          end
        end
        S_WAIT: begin
          if (wait_cnt_r == CNT_LAST) begin
            resp_valid <= 1'b1;
            resp_rdata <= load_extract(data_sram_rdata, size_r, signed_r, addr_r[1:0]);
          end else begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
          end
        end
        S_FWD: begin
          resp_valid <= 1'b1;
          resp_rdata <= load_extract(fwd_data_r, size_r, signed_r, addr_r[1:0]);
        end
        S_EXC: begin
          resp_valid    <= 1'b1;
          resp_adel     <= ~wr_r;
          resp_ades     <= wr_r;
          resp_badvaddr <= addr_r;
        end
        default: begin
        end
      endcase
    end
  end

  // Last-write buffer: same-word stores merge lanes, a different word replaces it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fwd_valid_r <= 1'b0;
      fwd_idx_r   <= {IDX_W{1'b0}};
      fwd_data_r  <= 32'h0000_0000;
      fwd_mask_r  <= 4'b0000;
    end else if ((FWD_EN != 0) && (state_r == S_ISSUE) && wr_r) begin
      fwd_valid_r <= 1'b1;
      fwd_idx_r   <= addr_r[ADDR_W-1:2];
      if (fwd_valid_r && (fwd_idx_r == addr_r[ADDR_W-1:2])) begin
        fwd_data_r <= (fwd_data_r & ~lane_bits_s) | (lane_data_r & lane_bits_s);
        fwd_mask_r <= fwd_mask_r | lane_mask_r;
      end else begin
        fwd_data_r <= lane_data_r & lane_bits_s;
        fwd_mask_r <= lane_mask_r;
      end
    end
  end

endmodule

// File: tb/tb_dm_lsu.sv
// Scoreboard bench for dm_lsu: instance 0 has RD_LAT=1/FWD_EN=1, instance 1 has
// RD_LAT=3/FWD_EN=0; both share one behavioural SRAM image.
module tb_dm_lsu;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_wr = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [8:0]  req_addr = 9'h000;
  logic [31:0] req_wdata = 32'h0;
  int          sel = 0;

  logic        valid   [2];
  logic        ready   [2];
  logic        rvalid  [2];
  logic [31:0] rdata   [2];
  logic        adel    [2];
  logic        ades    [2];
  logic [8:0]  badva   [2];
  logic        sen     [2];
  logic [3:0]  swen    [2];
  logic [31:0] saddr   [2];
  logic [31:0] swdata  [2];
  logic [31:0] srdata  [2];

  logic [31:0] mem [128] = '{default: 32'h0};

  typedef struct {int inst; int cyc; logic [31:0] rdata; logic adel; logic ades; logic [8:0] bad;} resp_t;
  typedef struct {int inst; int cyc; logic [3:0] wen; logic [31:0] wdata; logic [31:0] addr;} strobe_t;
  resp_t   resp_q[$];
  strobe_t strobe_q[$];

  int cyc = 0;
  int n_vec = 0;
  int n_miss = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign valid[0] = req_valid & (sel == 0);
  assign valid[1] = req_valid & (sel == 1);

  dm_lsu #(.ADDR_W(9), .RD_LAT(1), .FWD_EN(1)) u_dut0 (
    .clk(clk), .resetn(resetn), .req_valid(valid[0]), .req_ready(ready[0]),
    .req_wr(req_wr), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(rvalid[0]), .resp_rdata(rdata[0]), .resp_adel(adel[0]),
    .resp_ades(ades[0]), .resp_badvaddr(badva[0]), .data_sram_en(sen[0]), .data_sram_wen(swen[0]),
    .data_sram_addr(saddr[0]), .data_sram_wdata(swdata[0]), .data_sram_rdata(srdata[0]));

  dm_lsu #(.ADDR_W(9), .RD_LAT(3), .FWD_EN(0)) u_dut1 (
    .clk(clk), .resetn(resetn), .req_valid(valid[1]), .req_ready(ready[1]),
    .req_wr(req_wr), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(rvalid[1]), .resp_rdata(rdata[1]), .resp_adel(adel[1]),
    .resp_ades(ades[1]), .resp_badvaddr(badva[1]), .data_sram_en(sen[1]), .data_sram_wen(swen[1]),
    .data_sram_addr(saddr[1]), .data_sram_wdata(swdata[1]), .data_sram_rdata(srdata[1]));

  // SRAM image: read data is captured at the strobe edge and held until the next read.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (sen[i]) begin
        if (swen[i] != 4'b0000) begin
          for (int b = 0; b < 4; b++) begin
            if (swen[i][b]) mem[saddr[i][8:2]][8*b +: 8] <= swdata[i][8*b +: 8];
          end
        end else begin
          srdata[i] <= mem[saddr[i][8:2]];
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop expectations whenever a DUT responds or strobes the SRAM.
  always @(negedge clk) begin
    resp_t e;
    strobe_t s;
    for (int i = 0; i < 2; i++) begin
      if (rvalid[i]) begin
        if (resp_q.size() == 0) begin
          check("resp_unexpected", 32'(i), 32'hFFFF_FFFF);
        end else begin
          e = resp_q.pop_front();
          check("resp_inst", 32'(i), 32'(e.inst));
          check("resp_cycle", 32'(cyc), 32'(e.cyc));
          check("resp_rdata", rdata[i], e.rdata);
          check("resp_adel", 32'(adel[i]), 32'(e.adel));
          check("resp_ades", 32'(ades[i]), 32'(e.ades));
          check("resp_badvaddr", 32'(badva[i]), 32'(e.bad));
        end
      end
      if (sen[i]) begin
        if (strobe_q.size() == 0) begin
          check("strobe_unexpected", 32'(i), 32'hFFFF_FFFF);
        end else begin
          s = strobe_q.pop_front();
          check("strobe_inst", 32'(i), 32'(s.inst));
          check("strobe_cycle", 32'(cyc), 32'(s.cyc));
          check("strobe_wen", 32'(swen[i]), 32'(s.wen));
          check("strobe_wdata", swdata[i], s.wdata);
          check("strobe_addr", saddr[i], s.addr);
        end
      end
    end
  end

  task automatic do_req(input int inst, input bit wr, input logic [1:0] size, input bit sgn,
                        input logic [8:0] addr, input logic [31:0] wd, input int lat,
                        input bit strobe, input bit push_resp, input logic [31:0] erd,
                        input bit eadel, input bit eades, input logic [3:0] ewen,
                        input logic [31:0] ewd);
    int t;
    int g;
    resp_t r;
    strobe_t s;
    @(negedge clk);
    sel = inst; req_wr = wr; req_size = size; req_signed = sgn; req_addr = addr;
    req_wdata = wd; req_valid = 1'b1;
    g = 0;
    while (!ready[inst] && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) check("accept_timeout", 32'd0, 32'd1);
    t = cyc;
    if (strobe) begin
      s.inst = inst; s.cyc = t + 1; s.wen = ewen; s.wdata = ewd;
      s.addr = {23'h0, addr[8:2], 2'b00};
      strobe_q.push_back(s);
    end
    if (push_resp) begin
      r.inst = inst; r.cyc = t + lat; r.rdata = erd; r.adel = eadel; r.ades = eades;
      r.bad = (eadel | eades) ? addr : 9'h000;
      resp_q.push_back(r);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_wr = ~wr; req_size = ~size; req_signed = ~sgn;
    req_addr = 9'h1FF; req_wdata = 32'hFFFF_FFFF;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((resp_q.size() != 0 || strobe_q.size() != 0 || !ready[sel]) && g < 40) begin
      @(negedge clk);
      g++;
    end
    if (g >= 40) check("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_ready", 32'(ready[i]), 32'd1);
      check("rst_resp_valid", 32'(rvalid[i]), 32'd0);
      check("rst_sram_en", 32'(sen[i]), 32'd0);
      check("rst_sram_wen", 32'(swen[i]), 32'd0);
      check("rst_resp_rdata", rdata[i], 32'd0);
    end
    resetn = 1'b1;

    // Instance 1: no forwarding, RD_LAT=3.
    do_req(1, 1, 2'b10, 0, 9'h010, 32'hDEAD_BEEF, 2, 1, 1, 32'h0, 0, 0, 4'hF, 32'hDEAD_BEEF); drain();
    do_req(1, 0, 2'b10, 0, 9'h010, 32'h0, 5, 1, 1, 32'hDEAD_BEEF, 0, 0, 4'h0, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("busy_ready", 32'(ready[1]), 32'd0);
    end
    @(negedge clk);
    check("idle_ready", 32'(ready[1]), 32'd1);
    drain();
    do_req(1, 1, 2'b00, 0, 9'h013, 32'h0000_0080, 2, 1, 1, 32'h0, 0, 0, 4'b1000, 32'h8080_8080); drain();
    do_req(1, 0, 2'b00, 1, 9'h013, 32'h0, 5, 1, 1, 32'hFFFF_FF80, 0, 0, 4'h0, 32'h0); drain();
    do_req(1, 0, 2'b00, 0, 9'h013, 32'h0, 5, 1, 1, 32'h0000_0080, 0, 0, 4'h0, 32'h0); drain();
    do_req(1, 0, 2'b01, 1, 9'h011, 32'h0, 2, 0, 1, 32'h0, 1, 0, 4'h0, 32'h0); drain();
    do_req(1, 1, 2'b10, 0, 9'h012, 32'h1111_1111, 2, 0, 1, 32'h0, 0, 1, 4'h0, 32'h0); drain();
    do_req(1, 0, 2'b01, 0, 9'h010, 32'h0, 5, 1, 1, 32'h0000_BEEF, 0, 0, 4'h0, 32'h0); drain();
    do_req(1, 0, 2'b01, 1, 9'h012, 32'h0, 5, 1, 1, 32'hFFFF_80AD, 0, 0, 4'h0, 32'h0); drain();
    do_req(1, 1, 2'b01, 0, 9'h016, 32'hFFFF_1234, 2, 1, 1, 32'h0, 0, 0, 4'b1100, 32'h1234_1234); drain();
    do_req(1, 0, 2'b10, 0, 9'h014, 32'h0, 5, 1, 1, 32'h1234_0000, 0, 0, 4'h0, 32'h0); drain();

    // Instance 0: forwarding, RD_LAT=1.
    do_req(0, 1, 2'b10, 0, 9'h020, 32'h1234_5678, 2, 1, 1, 32'h0, 0, 0, 4'hF, 32'h1234_5678); drain();
    do_req(0, 0, 2'b01, 0, 9'h022, 32'h0, 2, 0, 1, 32'h0000_1234, 0, 0, 4'h0, 32'h0); drain();
    do_req(0, 0, 2'b00, 1, 9'h021, 32'h0, 2, 0, 1, 32'h0000_0056, 0, 0, 4'h0, 32'h0); drain();
    do_req(0, 1, 2'b00, 0, 9'h031, 32'h0000_00AA, 2, 1, 1, 32'h0, 0, 0, 4'b0010, 32'hAAAA_AAAA); drain();
    do_req(0, 0, 2'b01, 1, 9'h030, 32'h0, 3, 1, 1, 32'hFFFF_AA00, 0, 0, 4'h0, 32'h0); drain();
    do_req(0, 1, 2'b00, 0, 9'h030, 32'h0000_0055, 2, 1, 1, 32'h0, 0, 0, 4'b0001, 32'h5555_5555); drain();
    do_req(0, 0, 2'b01, 1, 9'h030, 32'h0, 2, 0, 1, 32'hFFFF_AA55, 0, 0, 4'h0, 32'h0); drain();
    do_req(0, 0, 2'b10, 0, 9'h020, 32'h0, 3, 1, 1, 32'h1234_5678, 0, 0, 4'h0, 32'h0); drain();
    do_req(0, 0, 2'b11, 0, 9'h030, 32'h0, 3, 1, 1, 32'h0000_AA55, 0, 0, 4'h0, 32'h0); drain();
    do_req(0, 0, 2'b01, 1, 9'h013, 32'h0, 2, 0, 1, 32'h0, 1, 0, 4'h0, 32'h0); drain();

    // Reset while instance 1 waits on its SRAM read: the access must vanish.
    do_req(1, 0, 2'b10, 0, 9'h010, 32'h0, 5, 1, 0, 32'h0, 0, 0, 4'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("abort_sram_en", 32'(sen[1]), 32'd0);
    check("abort_resp_valid", 32'(rvalid[1]), 32'd0);
    check("abort_ready", 32'(ready[1]), 32'd1);
    repeat (4) @(negedge clk);
    resetn = 1'b1;
    do_req(1, 0, 2'b10, 0, 9'h010, 32'h0, 5, 1, 1, 32'h80AD_BEEF, 0, 0, 4'h0, 32'h0); drain();
    do_req(0, 0, 2'b01, 0, 9'h030, 32'h0, 3, 1, 1, 32'h0000_AA55, 0, 0, 4'h0, 32'h0); drain();

    repeat (3) @(negedge clk);
    check("resp_q_empty", 32'(resp_q.size()), 32'd0);
    check("strobe_q_empty", 32'(strobe_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
